aer_spike_arbiter: RTL and testbench
====================================

# aer_spike_arbiter

Collects single-cycle spike pulses from a bank of `NUM_NEURONS` LIF neurons and serializes them onto one Address-Event Representation (AER) output. Each event carries the neuron index and the current timestep over a valid/ready handshake. The block sits between the neuron array and the AER router / STDP event consumer. It buffers one outstanding spike per neuron, arbitrates round-robin, and counts spikes lost to overrun.

## Interface
- `NUM_NEURONS`, default 8: number of spike inputs; must be ≤ 2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, default 3: width of the AER address.
- `TS_WIDTH`, default 8: width of the timestep counter.
- `DROP_WIDTH`, default 8: width of the saturating drop counter.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `spike_in`  in  `NUM_NEURONS`  per-neuron spike pulses; a bit high in a cycle is one spike.
- `timestep_tick`  in  1  one-cycle pulse that advances the timestep counter.
- `aer_valid`  out  1  event present on `aer_addr` / `aer_ts`.
- `aer_ready`  in  1  consumer accepts the event when high together with `aer_valid`.
- `aer_addr`  out  `ADDR_WIDTH`  index of the spiking neuron.
- `aer_ts`  out  `TS_WIDTH`  timestep at which the event was loaded.
- `pending`  out  `NUM_NEURONS`  registered per-neuron outstanding-spike flags.
- `drop_count`  out  `DROP_WIDTH`  saturating count of lost spikes.
- `drained`  out  1  high when `pending`==0 and the FSM is IDLE.

## Operation
- **Pending set/clear:**
  - At each edge, `pending[i]` is set if `spike_in[i]`.
  - `pending[i]` is cleared when event `i` is accepted (`aer_valid & aer_ready` with `aer_addr`==i).
  - Set has priority over clear: a spike arriving in the accept cycle re-arms the bit. This is not a drop.
- **Drop:**
  - `spike_in[i]` high while `pending[i]` is already 1 and event `i` is not being accepted that cycle means the spike is lost.
  - `drop_count` adds the number of lost spikes in that cycle (popcount) and saturates at all-ones.
- **Timestep counter:** increments on `timestep_tick` and wraps from 2^`TS_WIDTH`−1 to 0.
- **FSM states:** IDLE and PRESENT.
  - IDLE: if registered `pending`≠0, load the winner into `aer_addr`, load the counter's current (pre-increment) value into `aer_ts`, assert `aer_valid`, and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT, `aer_ready`=0: hold `aer_addr`, `aer_ts` and `aer_valid` stable. The outputs must not change while stalled.
  - PRESENT, `aer_ready`=1: set `last_grant`=`aer_addr`. Then evaluate `pending` with the accepted bit masked and new `spike_in` excluded:
    - if nonzero, load the next winner back-to-back and stay in PRESENT;
    - otherwise deassert `aer_valid` and go to IDLE.
- **Round-robin:**
  - Search `last_grant`+1, +2, … modulo `NUM_NEURONS`; the first set bit wins.
  - `last_grant` resets to `NUM_NEURONS`−1, so neuron 0 has first priority after reset.
  - Indices ≥ `NUM_NEURONS` are never produced.

## Timing
- **Reset values:** `aer_valid`=0, `aer_addr`=0, `aer_ts`=0, `pending`=0, `drop_count`=0, `drained`=1. Internally, timestep counter=0 and FSM=IDLE.
- Reset asserted mid-handshake clears everything immediately; the in-flight event and all pending spikes are discarded.
- **Latency:** `spike_in[i]` sampled at edge E0 sets `pending[i]` after E0. With the FSM idle, `aer_valid` rises after E1.
- **Throughput:**
  - One event per cycle while `aer_ready` is held high and more than one bit is pending.
  - A lone event costs one idle cycle between consecutive accepts.
- `drained` is combinational from registered state only; it has no path from the inputs.
- `timestep_tick` in the same cycle as a load: `aer_ts` gets the pre-increment value.

## Test plan
- **Reset and single spike:** after reset, pulse `spike_in`=8'b0000_0100 with `aer_ready`=1. `aer_valid` rises 2 edges later with `aer_addr`=2 and `aer_ts`=0, is accepted, then `drained`=1.
- **Round-robin burst:** `spike_in`=8'hFF for one cycle, `aer_ready`=1. Addresses come out 0,1,…,7 on consecutive cycles. A second 8'hFF burst then yields 0..7 again, following `last_grant`=7.
- **Backpressure and drop:** spike neuron 3, hold `aer_ready`=0 for 5 cycles, and pulse neuron 3 twice more. `aer_addr`/`aer_ts` stay stable, `drop_count`=2, and after release exactly one event for neuron 3 is delivered.
- **Re-arm on accept:** pulse neuron 5 in the same cycle its event is accepted. No drop is counted, and a second event for 5 follows.
- **Timestep wrap and saturation:**
  - With `TS_WIDTH`=8, 256 ticks return `aer_ts` to 0.
  - Forcing 300 drops leaves `drop_count`=255.
- **Async reset mid-handshake:** assert `rst_n`=0 with `aer_valid`=1 and `pending`=8'hF0. All outputs return to their reset values before the next clock edge.

Source files
------------

// File: rtl/aer_spike_arbiter.sv
// Serializes per-neuron spike pulses onto one AER valid/ready stream, round-robin, one buffered spike per neuron.
// A spike appears on the AER port two edges after it is sampled; a stalled event holds addr/ts/valid stable.
module aer_spike_arbiter #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int TS_WIDTH    = 8,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_NEURONS-1:0] i_spike_in,
  input  logic                   i_timestep_tick,
  output logic                   o_aer_valid,
  input  logic                   i_aer_ready,
  output logic [ADDR_WIDTH-1:0]  o_aer_addr,
  output logic [TS_WIDTH-1:0]    o_aer_ts,
  output logic [NUM_NEURONS-1:0] o_pending,
  output logic [DROP_WIDTH-1:0]  o_drop_count,
  output logic                   o_drained
);

  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int SUM_W = DROP_WIDTH + CNT_W;
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_WIDTH{1'b1}});

  typedef enum logic {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [TS_WIDTH-1:0]   ts;
  } aer_evt_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [NUM_NEURONS-1:0] r_pending;
  logic [ADDR_WIDTH-1:0]  r_last_grant;
  logic [TS_WIDTH-1:0]    r_ts;
  logic [DROP_WIDTH-1:0]  r_drop;
  aer_evt_t               r_evt;
  logic                   r_aer_valid;

  logic                   w_accept;
  logic                   w_load;
  logic [NUM_NEURONS-1:0] w_accept_mask;
  logic [NUM_NEURONS-1:0] w_req;
  logic [NUM_NEURONS-1:0] w_drop_vec;
  logic [ADDR_WIDTH-1:0]  w_rr_base;
  logic [ADDR_WIDTH-1:0]  w_winner;
  logic [SUM_W-1:0]       w_drop_sum;

  assign w_accept      = r_aer_valid & i_aer_ready;
  assign w_accept_mask = w_accept ? (NUM_NEURONS'(1) << r_evt.addr) : '0;
  // Arbitration sees only registered spikes minus the one leaving; new arrivals wait a cycle.
  assign w_req         = r_pending & ~w_accept_mask;
  assign w_drop_vec    = i_spike_in & w_req;
  assign w_rr_base     = w_accept ? r_evt.addr : r_last_grant;

  always_comb begin
    logic [IDX_W-1:0] v_idx;
    logic             v_found;
    w_winner = '0;
    v_found  = 1'b0;
    v_idx    = '0;
    for (int k = 1; k <= NUM_NEURONS; k++) begin
      v_idx = {1'b0, w_rr_base} + IDX_W'(k);
      if (v_idx >= IDX_W'(NUM_NEURONS)) begin
        v_idx = v_idx - IDX_W'(NUM_NEURONS);
      end
      if (!v_found && (|(w_req & (NUM_NEURONS'(1) << v_idx)))) begin
        v_found  = 1'b1;
        w_winner = v_idx[ADDR_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_drop_sum = SUM_W'(r_drop);
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_drop_sum = w_drop_sum + SUM_W'(w_drop_vec[i]);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_load       = 1'b1;
          w_next_state = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (i_aer_ready) begin
          if (|w_req) begin
            w_load = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending    <= '0;
      r_last_grant <= ADDR_WIDTH'(NUM_NEURONS - 1);
      r_ts         <= '0;
      r_drop       <= '0;
      r_evt        <= '0;
      r_aer_valid  <= 1'b0;
    end else begin
      r_pending   <= w_req | i_spike_in;
      r_drop      <= (w_drop_sum > DROP_MAX) ? '1 : w_drop_sum[DROP_WIDTH-1:0];
      r_ts        <= r_ts + TS_WIDTH'(i_timestep_tick);
      r_aer_valid <= (w_next_state == ST_PRESENT);
      if (w_accept) begin
        r_last_grant <= r_evt.addr;
      end
      // Timestamp is the counter value before any same-cycle tick.
      if (w_load) begin
        r_evt.addr <= w_winner;
        r_evt.ts   <= r_ts;
      end
    end
  end

  assign o_aer_valid  = r_aer_valid;
  assign o_aer_addr   = r_evt.addr;
  assign o_aer_ts     = r_evt.ts;
  assign o_pending    = r_pending;
  assign o_drop_count = r_drop;
  assign o_drained    = (r_pending == '0) && (r_state == ST_IDLE);

endmodule

// File: tb/tb_aer_spike_arbiter.sv
// Bench for aer_spike_arbiter: cycle table for latency/re-arm, scoreboard for every accepted AER event.
module tb_aer_spike_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] spike_in;
  logic       tick;
  logic       aer_valid;
  logic       aer_ready;
  logic [2:0] aer_addr;
  logic [7:0] aer_ts;
  logic [7:0] pending;
  logic [7:0] drop_count;
  logic       drained;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] ts;
  } ev_t;

  typedef struct packed {
    logic [7:0] sp;
    logic       rdy;
    logic       tk;
    logic       ev;
    logic [2:0] addr;
    logic [7:0] ts;
    logic [7:0] pend;
    logic       drn;
  } vec_t;

  ev_t        sb_q[$];
  ev_t        mon_ev;
  logic       stall_seen = 1'b0;
  logic [2:0] st_addr;
  logic [7:0] st_ts;
  vec_t       tbl[8];
  int         n;

  always #5 clk = ~clk;

  aer_spike_arbiter #(
    .NUM_NEURONS(8),
    .ADDR_WIDTH (3),
    .TS_WIDTH   (8),
    .DROP_WIDTH (8)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_spike_in     (spike_in),
    .i_timestep_tick(tick),
    .o_aer_valid    (aer_valid),
    .i_aer_ready    (aer_ready),
    .o_aer_addr     (aer_addr),
    .o_aer_ts       (aer_ts),
    .o_pending      (pending),
    .o_drop_count   (drop_count),
    .o_drained      (drained)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] sp, input logic rdy, input logic tk);
    spike_in  = sp;
    aer_ready = rdy;
    tick      = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    spike_in  = '0;
    aer_ready = 1'b0;
    tick      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_ev(input logic [2:0] a, input logic [7:0] t);
    ev_t e;
    e.addr = a;
    e.ts   = t;
    sb_q.push_back(e);
  endtask

  task automatic wait_drained(input int max, output int cnt);
    cnt = 0;
    while (!drained && cnt < max) begin
      step(8'h00, 1'b1, 1'b0);
      cnt++;
    end
    chk("drain_timeout", 32'(drained), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},   32'(aer_valid),  32'd0);
    chk({tag, "_addr"},    32'(aer_addr),   32'd0);
    chk({tag, "_ts"},      32'(aer_ts),     32'd0);
    chk({tag, "_pending"}, 32'(pending),    32'd0);
    chk({tag, "_drop"},    32'(drop_count), 32'd0);
    chk({tag, "_drained"}, 32'(drained),    32'd1);
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("stall_valid", 32'(aer_valid), 32'd1);
        chk("stall_addr",  32'(aer_addr),  32'(st_addr));
        chk("stall_ts",    32'(aer_ts),    32'(st_ts));
      end
      if (aer_valid && aer_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_event_addr", 32'(aer_addr), 32'hFFFF);
        end else begin
          mon_ev = sb_q.pop_front();
          chk("ev_addr", 32'(aer_addr), 32'(mon_ev.addr));
          chk("ev_ts",   32'(aer_ts),   32'(mon_ev.ts));
        end
      end
      stall_seen = aer_valid && !aer_ready;
      st_addr    = aer_addr;
      st_ts      = aer_ts;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    //            sp     rdy   tk    ev    addr  ts     pend   drn
    tbl[0] = {8'h04, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'h04, 1'b0};
    tbl[1] = {8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'd0, 8'h04, 1'b0};
    tbl[2] = {8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0, 8'h00, 1'b1};
    tbl[3] = {8'h20, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 8'h20, 1'b0};
    tbl[4] = {8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'd1, 8'h20, 1'b0};
    tbl[5] = {8'h20, 1'b1, 1'b0, 1'b0, 3'd5, 8'd1, 8'h20, 1'b0};
    tbl[6] = {8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'd1, 8'h20, 1'b0};
    tbl[7] = {8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'd1, 8'h00, 1'b1};

    do_reset();
    chk_reset_vals("rst");

    // Single spike latency, lone-event idle gap, and re-arm on accept.
    push_ev(3'd2, 8'd0);
    push_ev(3'd5, 8'd1);
    push_ev(3'd5, 8'd1);
    for (int r = 0; r < 8; r++) begin
      step(tbl[r].sp, tbl[r].rdy, tbl[r].tk);
      chk($sformatf("tbl%0d_valid", r),   32'(aer_valid), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_addr", r),    32'(aer_addr),  32'(tbl[r].addr));
      chk($sformatf("tbl%0d_ts", r),      32'(aer_ts),    32'(tbl[r].ts));
      chk($sformatf("tbl%0d_pending", r), 32'(pending),   32'(tbl[r].pend));
      chk($sformatf("tbl%0d_drained", r), 32'(drained),   32'(tbl[r].drn));
    end
    chk("rearm_no_drop", 32'(drop_count), 32'd0);

    // Round-robin bursts: back-to-back 0..7, twice.
    do_reset();
    for (int a = 0; a < 8; a++) push_ev(3'(a), 8'd0);
    step(8'hFF, 1'b1, 1'b0);
    wait_drained(40, n);
    chk("burst1_cycles", 32'(n), 32'd9);
    for (int a = 0; a < 8; a++) push_ev(3'(a), 8'd1);
    step(8'hFF, 1'b1, 1'b1);
    wait_drained(40, n);
    chk("burst2_cycles", 32'(n), 32'd9);
    chk("burst2_last_addr", 32'(aer_addr), 32'd7);

    // Backpressure: stall 5 cycles, two extra spikes on neuron 3 are lost.
    do_reset();
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("bp_valid",   32'(aer_valid),  32'd1);
    chk("bp_addr",    32'(aer_addr),   32'd3);
    chk("bp_ts",      32'(aer_ts),     32'd0);
    chk("bp_drop",    32'(drop_count), 32'd2);
    chk("bp_pending", 32'(pending),    32'h08);
    push_ev(3'd3, 8'd0);
    wait_drained(10, n);
    chk("bp_accept_cycles", 32'(n), 32'd1);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Timestep wrap at 256 ticks.
    do_reset();
    for (int t = 0; t < 255; t++) step(8'h00, 1'b1, 1'b1);
    push_ev(3'd1, 8'd255);
    step(8'h02, 1'b1, 1'b0);
    wait_drained(10, n);
    step(8'h00, 1'b1, 1'b1);
    push_ev(3'd6, 8'd0);
    step(8'h40, 1'b1, 1'b0);
    wait_drained(10, n);

    // Drop counter saturation.
    do_reset();
    step(8'hFF, 1'b0, 1'b0);
    for (int c = 0; c < 31; c++) step(8'hFF, 1'b0, 1'b0);
    chk("drop_248", 32'(drop_count), 32'd248);
    for (int c = 0; c < 7; c++) step(8'hFF, 1'b0, 1'b0);
    chk("drop_sat", 32'(drop_count), 32'd255);
    step(8'h0F, 1'b0, 1'b0);
    chk("drop_sat_hold", 32'(drop_count), 32'd255);
    chk("sat_addr", 32'(aer_addr), 32'd0);

    // Async reset in the middle of a stalled handshake.
    do_reset();
    step(8'hF0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("ar_pre_valid",   32'(aer_valid), 32'd1);
    chk("ar_pre_addr",    32'(aer_addr),  32'd4);
    chk("ar_pre_pending", 32'(pending),   32'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(8'h00, 1'b1, 1'b0);
    chk_reset_vals("post_rst");

    chk("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
